// File: rtl/fig_01_block_rom_arbiter_if.sv
// ROM arbiter bus bundle: host passthrough, fetcher/ROM-buffer handshakes, ROM pins, status.
// master: requester/top-level side. slave: the arbiter.
interface fig_01_block_rom_arbiter_if;
  logic        ron;
  logic        fast;
  logic [23:0] ha;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic        fetch_rdy;
  logic        buf_req;
  logic [23:0] buf_addr;
  logic        buf_rdy;
  logic [7:0]  rom_q;
  logic [23:0] rom_a;
  logic [7:0]  rom_d;
  logic        busy;

  modport master (
    output ron, fast, ha, fetch_req, fetch_addr, buf_req, buf_addr, rom_d,
    input  fetch_rdy, buf_rdy, rom_q, rom_a, busy
  );

  modport slave (
    input  ron, fast, ha, fetch_req, fetch_addr, buf_req, buf_addr, rom_d,
    output fetch_rdy, buf_rdy, rom_q, rom_a, busy
  );
endinterface

// File: rtl/fig_01_block_rom_arbiter.sv
// GSU ROM bus arbiter: shares the external ROM between the instruction-cache fetcher and
// the ROM-buffer read unit, inserts per-access wait states, and passes the host address
// through whenever the GSU does not own ROM (ron=0).
// Optional build macro ROM_ARB_RR_EN: round-robin arbitration instead of fixed
// fetch-over-buffer priority.
module fig_01_block_rom_arbiter #(
  parameter int unsigned WAIT_SLOW = 5,
  parameter int unsigned WAIT_FAST = 3
) (
  input logic                       clk,
  input logic                       reset,
  fig_01_block_rom_arbiter_if.slave bus
);

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [23:0]       rom_a_q, rom_a_d;
  logic [7:0]        rom_q_q, rom_q_d;
  logic              fetch_rdy_q, fetch_rdy_d;
  logic              buf_rdy_q, buf_rdy_d;
  logic              gnt_buf_q, gnt_buf_d;  // current grantee: 0 = fetcher, 1 = ROM buffer
  logic              any_req;
  logic              pick_buf;
`ifdef ROM_ARB_RR_EN
  logic              last_buf_q, last_buf_d;  // last grant: 0 = fetcher, 1 = ROM buffer
`endif

  assign any_req = bus.fetch_req | bus.buf_req;

  // Winner selection among pending requests (only meaningful when any_req is high).
  always_comb begin
    pick_buf = 1'b0;
`ifdef ROM_ARB_RR_EN
    pick_buf = bus.buf_req & (~bus.fetch_req | ~last_buf_q);
`else
    pick_buf = ~bus.fetch_req;
`endif
  end

  // Next-state and next-register values for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rom_a_d     = rom_a_q;
    rom_q_d     = rom_q_q;
    gnt_buf_d   = gnt_buf_q;
    fetch_rdy_d = 1'b0;
    buf_rdy_d   = 1'b0;
`ifdef ROM_ARB_RR_EN
    last_buf_d  = last_buf_q;
`endif
    case (state_q)
      StIdle: begin
        if (!bus.ron) begin
          rom_a_d = bus.ha;
        end else if (any_req) begin
          gnt_buf_d = pick_buf;
          rom_a_d   = pick_buf ? bus.buf_addr : bus.fetch_addr;
          // fast is sampled only here; later changes do not stretch or shorten the access
          cnt_d     = bus.fast ? CntW'(WAIT_FAST - 1) : CntW'(WAIT_SLOW - 1);
          state_d   = StAccess;
`ifdef ROM_ARB_RR_EN
          last_buf_d = pick_buf;
`endif
        end
      end
      StAccess: begin
        if (!bus.ron) begin
          // Host reclaimed the bus: abandon the access; the request stays pending.
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          rom_q_d = bus.rom_d;
          state_d = StRecover;
          // A requester that dropped its request mid-access gets no ready pulse.
          if (gnt_buf_q) begin
            buf_rdy_d = bus.buf_req;
          end else begin
            fetch_rdy_d = bus.fetch_req;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rom_a_q     <= '0;
      rom_q_q     <= '0;
      fetch_rdy_q <= 1'b0;
      buf_rdy_q   <= 1'b0;
      gnt_buf_q   <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_buf_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_a_q     <= rom_a_d;
      rom_q_q     <= rom_q_d;
      fetch_rdy_q <= fetch_rdy_d;
      buf_rdy_q   <= buf_rdy_d;
      gnt_buf_q   <= gnt_buf_d;
`ifdef ROM_ARB_RR_EN
      last_buf_q  <= last_buf_d;
`endif
    end
  end

  // Busy covers an access in flight and any GSU request still waiting, including
  // requests held off while the host owns ROM.
  always_comb begin
    bus.busy = (state_q != StIdle) | any_req;
  end

  // Registered outputs to the bus bundle.
  always_comb begin
    bus.rom_a     = rom_a_q;
    bus.rom_q     = rom_q_q;
    bus.fetch_rdy = fetch_rdy_q;
    bus.buf_rdy   = buf_rdy_q;
  end

endmodule

// File: tb/tb_fig_01_block_rom_arbiter.sv
// Directed self-checking bench for fig_01_block_rom_arbiter (default build, fixed priority).
module tb_fig_01_block_rom_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fig_01_block_rom_arbiter_if bus ();

  fig_01_block_rom_arbiter #(
    .WAIT_SLOW (5),
    .WAIT_FAST (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call right after the grant edge: the ready pulse must appear exactly n edges later.
  task automatic expect_rdy(input string tag, input bit is_buf, input int n);
    for (int i = 1; i < n; i++) begin
      tick();
      check({tag, "_quiet"}, {31'd0, is_buf ? bus.buf_rdy : bus.fetch_rdy}, 32'd0);
    end
    tick();
    check({tag, "_pulse"}, {31'd0, is_buf ? bus.buf_rdy : bus.fetch_rdy}, 32'd1);
    check({tag, "_other"}, {31'd0, is_buf ? bus.fetch_rdy : bus.buf_rdy}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.ron        = 1'b1;
    bus.fast       = 1'b0;
    bus.ha         = 24'h0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 24'h0;
    bus.buf_req    = 1'b0;
    bus.buf_addr   = 24'h0;
    bus.rom_d      = 8'h0;
    tick();
    tick();
    check("rst_rom_a", {8'd0, bus.rom_a}, 32'h0);
    check("rst_rom_q", {24'd0, bus.rom_q}, 32'h0);
    check("rst_fetch_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
    check("rst_buf_rdy", {31'd0, bus.buf_rdy}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Slow fetch.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 24'h01_8000;
    bus.rom_d      = 8'hA5;
    tick();
    check("f1_rom_a", {8'd0, bus.rom_a}, 32'h018000);
    check("f1_busy", {31'd0, bus.busy}, 32'd1);
    expect_rdy("f1", 1'b0, 5);
    check("f1_rom_q", {24'd0, bus.rom_q}, 32'hA5);
    bus.fetch_req = 1'b0;
    tick();
    check("f1_rdy_drop", {31'd0, bus.fetch_rdy}, 32'd0);
    check("f1_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Fast buffer read; fast flips mid-access and must be ignored.
    bus.fast     = 1'b1;
    bus.buf_req  = 1'b1;
    bus.buf_addr = 24'h3F_FFFF;
    bus.rom_d    = 8'h5A;
    #1;
    check("b1_busy_req", {31'd0, bus.busy}, 32'd1);
    tick();
    check("b1_rom_a", {8'd0, bus.rom_a}, 32'h3FFFFF);
    bus.fast = 1'b0;
    expect_rdy("b1", 1'b1, 3);
    check("b1_rom_q", {24'd0, bus.rom_q}, 32'h5A);
    check("b1_busy_recover", {31'd0, bus.busy}, 32'd1);
    bus.buf_req = 1'b0;
    tick();
    check("b1_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Contested: fetch first, buffer 7 clocks later.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 24'h00_0100;
    bus.buf_req    = 1'b1;
    bus.buf_addr   = 24'h00_0200;
    bus.rom_d      = 8'h11;
    tick();
    check("c_first_addr", {8'd0, bus.rom_a}, 32'h000100);
    expect_rdy("c_fetch", 1'b0, 5);
    bus.fetch_req = 1'b0;
    tick();
    check("c_gap_addr", {8'd0, bus.rom_a}, 32'h000100);
    tick();
    check("c_second_addr", {8'd0, bus.rom_a}, 32'h000200);
    expect_rdy("c_buf", 1'b1, 5);
    bus.buf_req = 1'b0;
    tick();

    // Host owns ROM: passthrough and pending fetch.
    bus.ron        = 1'b0;
    bus.ha         = 24'h12_3456;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 24'h00_0400;
    tick();
    check("h_rom_a", {8'd0, bus.rom_a}, 32'h123456);
    check("h_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    check("h_no_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
    check("h_rom_a_hold", {8'd0, bus.rom_a}, 32'h123456);
    bus.ron = 1'b1;
    tick();
    check("h_grant_addr", {8'd0, bus.rom_a}, 32'h000400);

    // ron drops in the 2nd access clock: abort.
    tick();
    bus.ron   = 1'b0;
    bus.rom_d = 8'hEE;
    tick();
    check("ab_no_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
    check("ab_rom_q", {24'd0, bus.rom_q}, 32'h11);
    tick();
    check("ab_pass_addr", {8'd0, bus.rom_a}, 32'h123456);
    check("ab_rom_q2", {24'd0, bus.rom_q}, 32'h11);
    check("ab_no_rdy2", {31'd0, bus.fetch_rdy}, 32'd0);
    bus.ron = 1'b1;
    tick();
    check("ab_regrant", {8'd0, bus.rom_a}, 32'h000400);
    expect_rdy("ab_rerun", 1'b0, 5);
    check("ab_rerun_q", {24'd0, bus.rom_q}, 32'hEE);
    bus.fetch_req = 1'b0;
    tick();

    // Request dropped mid-access: data still captured, no ready.
    bus.fast       = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 24'h00_0600;
    bus.rom_d      = 8'h77;
    tick();
    tick();
    bus.fetch_req = 1'b0;
    tick();
    tick();
    check("dr_no_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
    check("dr_rom_q", {24'd0, bus.rom_q}, 32'h77);
    check("dr_busy_recover", {31'd0, bus.busy}, 32'd1);
    tick();
    check("dr_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-access, then re-grant of the held request.
    bus.fast     = 1'b0;
    bus.buf_req  = 1'b1;
    bus.buf_addr = 24'h0A_BCDE;
    bus.rom_d    = 8'h3C;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rm_rom_a", {8'd0, bus.rom_a}, 32'h0);
    check("rm_rom_q", {24'd0, bus.rom_q}, 32'h0);
    check("rm_buf_rdy", {31'd0, bus.buf_rdy}, 32'd0);
    reset = 1'b0;
    tick();
    check("rm_regrant", {8'd0, bus.rom_a}, 32'h0ABCDE);
    expect_rdy("rm_rerun", 1'b1, 5);
    check("rm_rom_q2", {24'd0, bus.rom_q}, 32'h3C);
    bus.buf_req = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
